spi_slave_gen: RTL and testbench

Parametrised SPI slave front-end for the register/RAM access path: deserialises command frames from `mosi` under `ss_n`, presents each complete frame to the memory-side controller as a parallel word with a one-cycle valid strobe, and serialises read data back on `miso`. It is the data-width- and bit-order-generic successor of the fixed 8-bit slave. It adds abort detection and a sticky read-address tracker. It sits between the SPI pins (SCK used directly as `clk`) and the single-port RAM controller.

---
 rtl/spi_slave_gen_if.sv | 42 ++++
 rtl/spi_slave_gen.sv | 159 +++++++++++++++
 tb/tb_spi_slave_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_gen_if.sv
// Pin-side and controller-side bundle for spi_slave_gen.
// frame_err is present only when SPI_SLV_FRAME_ERR_EN is defined.
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic              frame_err;
`endif

  modport slave (
    input  ss_n,
    input  mosi,
    input  tx_data,
    input  tx_valid,
`ifdef SPI_SLV_FRAME_ERR_EN
    output frame_err,
`endif
    output miso,
    output rx_data,
    output rx_valid
  );

  modport master (
    output ss_n,
    output mosi,
    output tx_data,
    output tx_valid,
`ifdef SPI_SLV_FRAME_ERR_EN
    input  frame_err,
`endif
    input  miso,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave: frame deserialiser, read-data serialiser, sticky read-address tracker.
// Optional abort strobe on frame_err when SPI_SLV_FRAME_ERR_EN is defined.
module spi_slave_gen #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic            clk_i,
  input logic            rst_ni,
  spi_slave_gen_if.slave spi_if
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;
  typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_TX, PH_DONE} phase_e;

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic [FRAME_W-1:0] frame_raw, frame_in;
  logic [DATA_W-1:0]  tx_ordered;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic               frame_err_q, frame_err_d;
`endif

  // The receive shifter is always MSB-first; LSB-first payloads are bit-reversed
  // on capture and on load, so the shifters themselves never change direction.
  always_comb begin
    frame_raw  = {rx_shift_q[FRAME_W-2:0], spi_if.mosi};
    frame_in   = frame_raw;
    tx_ordered = spi_if.tx_data;
    if (LSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) begin
        frame_in[i]   = frame_raw[DATA_W-1-i];
        tx_ordered[i] = spi_if.tx_data[DATA_W-1-i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      phase_q        <= PH_RX;
      cnt_q          <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_seen_q <= rd_addr_seen_d;
`ifdef SPI_SLV_FRAME_ERR_EN
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    rd_addr_seen_d = rd_addr_seen_q;
`ifdef SPI_SLV_FRAME_ERR_EN
    frame_err_d    = 1'b0;
`endif
    if (state_q != IDLE && spi_if.ss_n) begin
      state_d    = IDLE;
      phase_d    = PH_RX;
      cnt_d      = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
      miso_d     = 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
      frame_err_d = (state_q == CHK_CMD) || (phase_q != PH_DONE);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (!spi_if.ss_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          cnt_d   = '0;
          phase_d = PH_RX;
          if (!spi_if.mosi)        state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        default: begin
          case (phase_q)
            PH_RX: begin
              rx_shift_d = frame_raw;
              if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                rx_data_d  = frame_in;
                rx_valid_d = 1'b1;
                cnt_d      = '0;
                phase_d    = (state_q == READ_DATA) ? PH_WAIT : PH_DONE;
                if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            // Loading drives the first payload bit; cnt then counts bits already out.
            PH_WAIT: begin
              if (spi_if.tx_valid) begin
                miso_d     = tx_ordered[DATA_W-1];
                tx_shift_d = tx_ordered << 1;
                cnt_d      = CNT_W'(1);
                phase_d    = PH_TX;
              end
            end
            PH_TX: begin
              miso_d     = tx_shift_q[DATA_W-1];
              tx_shift_d = tx_shift_q << 1;
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                rd_addr_seen_d = 1'b0;
                phase_d        = PH_DONE;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: miso_d = 1'b0;
          endcase
        end
      endcase
    end
  end

  assign spi_if.miso     = miso_q;
  assign spi_if.rx_data  = rx_data_q;
  assign spi_if.rx_valid = rx_valid_q;
`ifdef SPI_SLV_FRAME_ERR_EN
  assign spi_if.frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: three instances (8-bit MSB-first, 8-bit LSB-first, 16-bit).
// Abort-strobe checks are compiled in when SPI_SLV_FRAME_ERR_EN is defined.
module tb_spi_slave_gen;
  logic        clk;
  logic        rst_n;
  logic [1:0]  which;
  logic        ssNDrv;
  logic        mosiDrv;
  logic [15:0] txDataDrv;
  logic        txValidDrv;
  int          checkCount;
  int          errorCount;

  spi_slave_gen_if #(.DATA_W(8))  if8 ();
  spi_slave_gen_if #(.DATA_W(8))  ifL ();
  spi_slave_gen_if #(.DATA_W(16)) if16 ();

  spi_slave_gen #(.DATA_W(8), .LSB_FIRST(1'b0)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .spi_if(if8)
  );
  spi_slave_gen #(.DATA_W(8), .LSB_FIRST(1'b1)) dutL (
    .clk_i(clk), .rst_ni(rst_n), .spi_if(ifL)
  );
  spi_slave_gen #(.DATA_W(16), .LSB_FIRST(1'b0)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .spi_if(if16)
  );

  // Only the selected instance sees the bus; the others stay deselected.
  assign if8.ss_n      = (which == 2'd0) ? ssNDrv : 1'b1;
  assign ifL.ss_n      = (which == 2'd1) ? ssNDrv : 1'b1;
  assign if16.ss_n     = (which == 2'd2) ? ssNDrv : 1'b1;
  assign if8.mosi      = mosiDrv;
  assign ifL.mosi      = mosiDrv;
  assign if16.mosi     = mosiDrv;
  assign if8.tx_data   = txDataDrv[7:0];
  assign ifL.tx_data   = txDataDrv[7:0];
  assign if16.tx_data  = txDataDrv;
  assign if8.tx_valid  = (which == 2'd0) ? txValidDrv : 1'b0;
  assign ifL.tx_valid  = (which == 2'd1) ? txValidDrv : 1'b0;
  assign if16.tx_valid = (which == 2'd2) ? txValidDrv : 1'b0;

  logic        misoMux;
  logic        rxValidMux;
  logic [17:0] rxDataMux;
  assign misoMux    = (which == 2'd0) ? if8.miso : (which == 2'd1) ? ifL.miso : if16.miso;
  assign rxValidMux = (which == 2'd0) ? if8.rx_valid : (which == 2'd1) ? ifL.rx_valid : if16.rx_valid;
  assign rxDataMux  = (which == 2'd0) ? {8'h00, if8.rx_data} :
                      (which == 2'd1) ? {8'h00, ifL.rx_data} : if16.rx_data;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic frameErrMux;
  assign frameErrMux = (which == 2'd0) ? if8.frame_err : (which == 2'd1) ? ifL.frame_err : if16.frame_err;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one frame and returns at the falling edge after the last bit was sampled.
  task send_frame(input int w, input logic sel, input logic [1:0] cmd,
                  input logic [15:0] payload, input bit lsb);
    @(negedge clk); ssNDrv = 1'b0; mosiDrv = 1'b0;
    @(negedge clk); mosiDrv = sel;
    @(negedge clk); mosiDrv = cmd[1];
    @(negedge clk); mosiDrv = cmd[0];
    for (int i = 0; i < w; i++) begin
      @(negedge clk); mosiDrv = lsb ? payload[i] : payload[w-1-i];
    end
    @(negedge clk);
  endtask

  task end_frame();
    ssNDrv = 1'b1;
    @(negedge clk);
  endtask

  task test_reset();
    #1;
    checkCount++;
    if (misoMux !== 1'b0 || rxValidMux !== 1'b0 || rxDataMux !== 18'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_state miso=%b rx_valid=%b rx_data=%h required 0/0/0", misoMux, rxValidMux, rxDataMux);
    end
`ifdef SPI_SLV_FRAME_ERR_EN
    checkCount++;
    if (frameErrMux !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_frame_err got %b required 0", frameErrMux);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task test_write();
    which = 2'd0;
    send_frame(8, 1'b0, 2'b00, 16'h0005, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h005) begin
      errorCount++;
      $display("[TB] FAIL wr_addr rx_valid=%b rx_data=%h required 1/005", rxValidMux, rxDataMux);
    end
    end_frame();
    checkCount++;
    if (rxValidMux !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL wr_addr_strobe_width rx_valid=%b required 0", rxValidMux);
    end
    send_frame(8, 1'b0, 2'b01, 16'h00A3, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h1A3) begin
      errorCount++;
      $display("[TB] FAIL wr_data rx_valid=%b rx_data=%h required 1/1A3", rxValidMux, rxDataMux);
    end
    end_frame();
  endtask

  task test_read();
    logic [7:0] exp;
    which = 2'd0;
    exp = 8'hA3;
    send_frame(8, 1'b1, 2'b10, 16'h0005, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h205) begin
      errorCount++;
      $display("[TB] FAIL rd_addr rx_valid=%b rx_data=%h required 1/205", rxValidMux, rxDataMux);
    end
    end_frame();
    send_frame(8, 1'b1, 2'b11, 16'h0000, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h300) begin
      errorCount++;
      $display("[TB] FAIL rd_data_frame rx_valid=%b rx_data=%h required 1/300", rxValidMux, rxDataMux);
    end
    txValidDrv = 1'b1; txDataDrv = 16'h00A3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      txValidDrv = 1'b0;
      checkCount++;
      if (misoMux !== exp[7-i]) begin
        errorCount++;
        $display("[TB] FAIL rd_miso_bit%0d got %b required %b", i, misoMux, exp[7-i]);
      end
    end
    @(negedge clk);
    checkCount++;
    if (misoMux !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL rd_miso_hold got %b required 0", misoMux);
    end
    end_frame();
`ifdef SPI_SLV_FRAME_ERR_EN
    checkCount++;
    if (frameErrMux !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL clean_deselect_frame_err got %b required 0", frameErrMux);
    end
`endif
    // Tracker cleared: a select-1 frame is an address again and ignores tx_valid.
    send_frame(8, 1'b1, 2'b10, 16'h0007, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h207) begin
      errorCount++;
      $display("[TB] FAIL rd_addr_again rx_valid=%b rx_data=%h required 1/207", rxValidMux, rxDataMux);
    end
    txValidDrv = 1'b1; txDataDrv = 16'h00FF;
    repeat (2) begin
      @(negedge clk);
      checkCount++;
      if (misoMux !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL rd_addr_ignores_tx miso=%b required 0", misoMux);
      end
    end
    txValidDrv = 1'b0;
    end_frame();
  endtask

  task test_abort();
    which = 2'd0;
    @(negedge clk); ssNDrv = 1'b0; mosiDrv = 1'b0;
    @(negedge clk); mosiDrv = 1'b0;
    @(negedge clk); mosiDrv = 1'b0;
    @(negedge clk); mosiDrv = 1'b1;
    @(negedge clk); mosiDrv = 1'b1;
    @(negedge clk); mosiDrv = 1'b0;
    @(negedge clk); mosiDrv = 1'b1;
    @(negedge clk); ssNDrv = 1'b1;
    @(negedge clk);
    checkCount++;
    if (rxValidMux !== 1'b0 || rxDataMux !== 18'h207) begin
      errorCount++;
      $display("[TB] FAIL abort_outputs rx_valid=%b rx_data=%h required 0/207", rxValidMux, rxDataMux);
    end
`ifdef SPI_SLV_FRAME_ERR_EN
    checkCount++;
    if (frameErrMux !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL abort_frame_err got %b required 1", frameErrMux);
    end
    @(negedge clk);
    checkCount++;
    if (frameErrMux !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL abort_frame_err_width got %b required 0", frameErrMux);
    end
`endif
    send_frame(8, 1'b0, 2'b01, 16'h003C, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h13C) begin
      errorCount++;
      $display("[TB] FAIL after_abort rx_valid=%b rx_data=%h required 1/13C", rxValidMux, rxDataMux);
    end
    end_frame();
  endtask

  task test_reset_midframe();
    which = 2'd0;
    send_frame(8, 1'b1, 2'b11, 16'h0000, 1'b0);
    txValidDrv = 1'b1; txDataDrv = 16'h00A3;
    @(negedge clk);
    txValidDrv = 1'b0;
    checkCount++;
    if (misoMux !== 1'b1 || rxDataMux !== 18'h300) begin
      errorCount++;
      $display("[TB] FAIL pre_reset miso=%b rx_data=%h required 1/300", misoMux, rxDataMux);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (misoMux !== 1'b0 || rxValidMux !== 1'b0 || rxDataMux !== 18'h0) begin
      errorCount++;
      $display("[TB] FAIL async_reset miso=%b rx_valid=%b rx_data=%h required 0/0/0", misoMux, rxValidMux, rxDataMux);
    end
    ssNDrv = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8, 1'b0, 2'b00, 16'h00AA, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h0AA) begin
      errorCount++;
      $display("[TB] FAIL post_reset_frame rx_valid=%b rx_data=%h required 1/0AA", rxValidMux, rxDataMux);
    end
    end_frame();
  endtask

  task test_lsb_first();
    logic [7:0] exp;
    which = 2'd1;
    exp = 8'hC5;
    send_frame(8, 1'b0, 2'b01, 16'h0005, 1'b1);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h105) begin
      errorCount++;
      $display("[TB] FAIL lsb_wr_data rx_valid=%b rx_data=%h required 1/105", rxValidMux, rxDataMux);
    end
    end_frame();
    send_frame(8, 1'b1, 2'b10, 16'h0005, 1'b1);
    checkCount++;
    if (rxDataMux !== 18'h205) begin
      errorCount++;
      $display("[TB] FAIL lsb_rd_addr rx_data=%h required 205", rxDataMux);
    end
    end_frame();
    send_frame(8, 1'b1, 2'b11, 16'h0000, 1'b1);
    txValidDrv = 1'b1; txDataDrv = 16'h00A3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      txValidDrv = 1'b0;
      checkCount++;
      if (misoMux !== exp[7-i]) begin
        errorCount++;
        $display("[TB] FAIL lsb_miso_bit%0d got %b required %b", i, misoMux, exp[7-i]);
      end
    end
    end_frame();
  endtask

  task test_width16();
    which = 2'd2;
    send_frame(16, 1'b0, 2'b01, 16'hBEEF, 1'b0);
    checkCount++;
    if (rxValidMux !== 1'b1 || rxDataMux !== 18'h1BEEF) begin
      errorCount++;
      $display("[TB] FAIL width16 rx_valid=%b rx_data=%h required 1/1BEEF", rxValidMux, rxDataMux);
    end
    end_frame();
    checkCount++;
    if (rxValidMux !== 1'b0 || rxDataMux !== 18'h1BEEF) begin
      errorCount++;
      $display("[TB] FAIL width16_hold rx_valid=%b rx_data=%h required 0/1BEEF", rxValidMux, rxDataMux);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    which      = 2'd0;
    ssNDrv     = 1'b1;
    mosiDrv    = 1'b0;
    txDataDrv  = 16'h0;
    txValidDrv = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reset_midframe();
    test_lsb_first();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
